mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive exec grants while fetch waits.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports f_req / f_ack  input / output  1 each  fetch requester handshake; fetch is always a read.
REQ-007 SHALL have port f_addr  input  ADDR_W  fetch address, driven from IP.
REQ-008 SHALL have ports e_req / e_we / e_ack  input / input / output  1 each  exec requester handshake; e_we=1 selects write.
REQ-009 SHALL have ports e_addr / e_wdata  input  ADDR_W / DATA_W  exec address and write data.
REQ-010 SHALL have port rd_data  output  DATA_W  read data returned to whichever requester is acked.
REQ-011 SHALL have ports mem_rd / mem_wr  output  1 each  single-port memory strobes.
REQ-012 SHALL have ports mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and write data.
REQ-013 SHALL have port mem_rdata  input  DATA_W  synchronous memory read data, valid the cycle after mem_rd.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT_F, GRANT_E, ACK_F, ACK_E.
REQ-015 In IDLE, SHALL sample requests and transition as follows: e_req only -> GRANT_E; f_req only -> GRANT_F; both -> GRANT_E unless REQ-024 applies; none -> IDLE.
REQ-016 On leaving IDLE, SHALL latch the winner's addr, we and wdata; later requester input changes SHALL be ignored until the next IDLE.
REQ-017 In GRANT_x, SHALL drive mem_addr and mem_wdata from the latched values, and assert exactly one of mem_rd/mem_wr for exactly one cycle.
REQ-018 GRANT_x SHALL always go to ACK_x, and ACK_x SHALL always go to IDLE; each access occupies 3 cycles, with ack two cycles after the IDLE sampling cycle.
REQ-019 In ACK_x, SHALL assert the matching ack for exactly one cycle; the other ack SHALL stay 0.
REQ-020 In ACK_x for a read, SHALL drive rd_data = mem_rdata; in all other cycles rd_data SHALL be 0.
REQ-021 Requesters SHALL hold req and operands stable until ack; a req still high in the ACK cycle SHALL be treated as a new request only in the following IDLE.
REQ-022 mem_rd, mem_wr, f_ack and e_ack SHALL never be high simultaneously with each other.

Reset
REQ-023 When rst=1 at a rising edge, SHALL force IDLE and clear latched operands and the streak counter; in the next cycle all outputs SHALL be 0. A reset mid-access (GRANT or ACK) SHALL abort the access with no ack.

Configuration
REQ-024 With MEM_ARB_STARVE_EN defined: a counter SHALL increment on each exec grant while f_req=1, and clear on a fetch grant or when f_req=0 in IDLE; when the counter equals STARVE_LIMIT and both requests are present, IDLE SHALL go to GRANT_F.
REQ-025 Without MEM_ARB_STARVE_EN: strict exec priority, no counter logic; STARVE_LIMIT SHALL be unused.

Structure
REQ-026 The state encoding and the default widths of the ADDR_W/DATA_W constants SHALL live in shared package stack_pkg, for reuse by fsm and the datapath.
REQ-027 The streak counter SHALL be sub-module mem_arb_starve_ctr, instantiated only under MEM_ARB_STARVE_EN; the rest SHALL be flat.

Verification
REQ-028 Reset test: rst=1 for 2 cycles mid-GRANT_E -> no e_ack; all outputs 0 in the cycle after reset.
REQ-029 Single fetch: f_req=1, f_addr=0x10, memory[0x10]=0xA5 -> mem_rd=1, mem_addr=0x10 at +1; f_ack=1, rd_data=0xA5 at +2.
REQ-030 Exec write: e_req=1, e_we=1, e_addr=0x20, e_wdata=0x3C -> mem_wr=1 at +1, e_ack=1 and rd_data=0 at +2; a later read of 0x20 returns 0x3C.
REQ-031 Collision: f_req=e_req=1 in the same cycle -> exec served first; fetch acked 3 cycles after e_ack.
REQ-032 Starvation with macro and STARVE_LIMIT=4: e_req and f_req held high -> 4 e_acks then 1 f_ack, repeating. Without the macro -> no f_ack while e_req is held.
REQ-033 Exclusivity check: throughout all scenarios, assertion that at most one of mem_rd/mem_wr/f_ack/e_ack is high, and each ack lasts exactly one cycle.

Source files
------------

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared arbiter FSM encoding and default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

   localparam int C_ADDR_W_DEFAULT = 8;
   localparam int C_DATA_W_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT_F = 3'd1,
      ST_GRANT_E = 3'd2,
      ST_ACK_F   = 3'd3,
      ST_ACK_E   = 3'd4
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Counts consecutive exec grants taken while fetch is waiting.
//               o_at_limit tells the arbiter to hand the next slot to fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   localparam int C_CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [C_CNT_W-1:0] cnt_q;
   logic [C_CNT_W-1:0] cnt_d;

   // Clear has priority; the count saturates at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != C_CNT_W'(STARVE_LIMIT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Streak register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_at_limit = (cnt_q == C_CNT_W'(STARVE_LIMIT));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch/exec) arbiter for a single-port
//               synchronous memory. Exec has priority; every access takes
//               IDLE -> GRANT -> ACK. Optional anti-starvation for fetch is
//               enabled by defining MEM_ARB_STARVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import stack_pkg::*;
#(
   parameter int ADDR_W       = C_ADDR_W_DEFAULT,
   parameter int DATA_W       = C_DATA_W_DEFAULT,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   output logic              f_ack,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic              e_req,
   input  logic              e_we,
   output logic              e_ack,
   input  logic [ADDR_W-1:0] e_addr,
   input  logic [DATA_W-1:0] e_wdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic              f_ack_q, f_ack_d;
   logic              e_ack_q, e_ack_d;
   logic              rd_sel_q, rd_sel_d;

   logic              w_idle;
   logic              w_starve;
   logic              w_pick_f;
   logic              w_pick_e;

   // Winner selection in IDLE; w_starve comes straight from a register.
   assign w_idle   = (state_q == ST_IDLE);
   assign w_pick_f = f_req & (~e_req | w_starve);
   assign w_pick_e = e_req & ~w_pick_f;

`ifdef MEM_ARB_STARVE_EN
   mem_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_idle & w_pick_e & f_req),
      .i_clr      (w_idle & (~f_req | w_pick_f)),
      .o_at_limit (w_starve)
   );
`else
   assign w_starve = 1'b0;
`endif

   // Next-state, operand latch and next-cycle strobe/ack computation.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      f_ack_d  = 1'b0;
      e_ack_d  = 1'b0;
      rd_sel_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_pick_e) begin
               state_d  = ST_GRANT_E;
               addr_d   = e_addr;
               wdata_d  = e_wdata;
               we_d     = e_we;
               mem_wr_d = e_we;
               mem_rd_d = ~e_we;
            end else if (w_pick_f) begin
               state_d  = ST_GRANT_F;
               addr_d   = f_addr;
               wdata_d  = '0;
               we_d     = 1'b0;
               mem_rd_d = 1'b1;
            end
         end
         ST_GRANT_F: begin
            state_d  = ST_ACK_F;
            f_ack_d  = 1'b1;
            rd_sel_d = 1'b1;
         end
         ST_GRANT_E: begin
            state_d  = ST_ACK_E;
            e_ack_d  = 1'b1;
            rd_sel_d = ~we_q;
         end
         ST_ACK_F, ST_ACK_E: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched operands and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         f_ack_q  <= 1'b0;
         e_ack_q  <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         f_ack_q  <= f_ack_d;
         e_ack_q  <= e_ack_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign f_ack     = f_ack_q;
   assign e_ack     = e_ack_q;
   // Memory read data is only valid in the ACK cycle of a read.
   assign rd_data   = rd_sel_q ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a synchronous memory
//               model, a shadow copy for expected read data and an ack
//               scoreboard. Honors MEM_ARB_STARVE_EN for the starvation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       f_req = 1'b0;
   logic       f_ack;
   logic [7:0] f_addr = '0;
   logic       e_req = 1'b0;
   logic       e_we = 1'b0;
   logic       e_ack;
   logic [7:0] e_addr = '0;
   logic [7:0] e_wdata = '0;
   logic [7:0] rd_data;
   logic       mem_rd;
   logic       mem_wr;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata = '0;

   typedef struct packed {
      logic       is_f;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] mem    [256];
   logic [7:0] shadow [256];
   int         n_cmp = 0;
   int         n_err = 0;
   logic       f_prev = 1'b0;
   logic       e_prev = 1'b0;

   mem_arbiter #(
      .ADDR_W       (8),
      .DATA_W       (8),
      .STARVE_LIMIT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .f_req     (f_req),
      .f_ack     (f_ack),
      .f_addr    (f_addr),
      .e_req     (e_req),
      .e_we      (e_we),
      .e_ack     (e_ack),
      .e_addr    (e_addr),
      .e_wdata   (e_wdata),
      .rd_data   (rd_data),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Synchronous single-port memory, preset during reset.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         mem[8'h10] <= 8'hA5;
         mem_rdata  <= '0;
      end else begin
         if (mem_wr) mem[mem_addr] <= mem_wdata;
         if (mem_rd) mem_rdata <= mem[mem_addr];
      end
   end

   // Per-cycle monitor: exclusivity, single-cycle acks, scoreboard pop.
   always @(negedge clk) begin
      if (!rst) begin
         check("excl", {31'b0, ($countones({mem_rd, mem_wr, f_ack, e_ack}) <= 1)}, 1);
         check("ack_len", {30'b0, f_ack & f_prev, e_ack & e_prev}, 0);
         if (f_ack || e_ack) begin
            if (sb.size() == 0) begin
               check("sb_unexp", {30'b0, f_ack, e_ack}, 0);
            end else begin
               mon_e = sb.pop_front();
               check("ack_kind", {31'b0, f_ack}, {31'b0, mon_e.is_f});
               check("rd_data", {24'b0, rd_data}, {24'b0, mon_e.data});
            end
         end
      end
      f_prev = f_ack;
      e_prev = e_ack;
   end

   // One uncontended access; starts and ends on a negedge in IDLE.
   task automatic access(input logic is_f, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata);
      exp_t e;
      e.is_f = is_f;
      e.data = we ? 8'h00 : shadow[addr];
      if (we) shadow[addr] = wdata;
      sb.push_back(e);
      if (is_f) begin
         f_req = 1'b1; f_addr = addr;
      end else begin
         e_req = 1'b1; e_we = we; e_addr = addr; e_wdata = wdata;
      end
      @(negedge clk);
      check("acc_rd", {31'b0, mem_rd}, {31'b0, ~we});
      check("acc_wr", {31'b0, mem_wr}, {31'b0, we});
      check("acc_addr", {24'b0, mem_addr}, {24'b0, addr});
      if (we) check("acc_wdata", {24'b0, mem_wdata}, {24'b0, wdata});
      @(negedge clk);
      check("acc_ack", {30'b0, f_ack, e_ack}, is_f ? 32'd2 : 32'd1);
      f_req = 1'b0;
      e_req = 1'b0;
      e_we  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      int   k;
      int   cnt;
      logic [7:0] a;
      logic [7:0] d;

      for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
      shadow[8'h10] = 8'hA5;

      // Power-on reset.
      @(negedge clk);
      @(negedge clk);
      check("rst_out", {4'b0, mem_rd, mem_wr, f_ack, e_ack, mem_addr, mem_wdata, rd_data}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of an exec grant aborts the access.
      e_req = 1'b1; e_we = 1'b0; e_addr = 8'h30;
      @(negedge clk);
      check("rst_pre_grant", {31'b0, mem_rd}, 1);
      rst = 1'b1; e_req = 1'b0; e_addr = '0;
      @(negedge clk);
      check("rst_mid_out", {4'b0, mem_rd, mem_wr, f_ack, e_ack, mem_addr, mem_wdata, rd_data}, 0);
      @(negedge clk);
      check("rst_mid_noack", {31'b0, e_ack}, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_post_noack", {30'b0, f_ack, e_ack}, 0);
      end

      // Single fetch, exec write, read-back through both ports.
      access(1'b1, 1'b0, 8'h10, 8'h00);
      access(1'b0, 1'b1, 8'h20, 8'h3C);
      access(1'b0, 1'b0, 8'h20, 8'h00);
      access(1'b1, 1'b0, 8'h20, 8'h00);

      // A few randomized write/read pairs.
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom_range(8'h40, 8'h7F));
         d = 8'($urandom);
         access(1'b0, 1'b1, a, d);
         access(1'b1, 1'b0, a, 8'h00);
         access(1'b0, 1'b0, a, 8'h00);
      end

      // Collision: exec first, fetch acked three cycles later.
      e.is_f = 1'b0; e.data = shadow[8'h30]; sb.push_back(e);
      e.is_f = 1'b1; e.data = shadow[8'h10]; sb.push_back(e);
      e_req = 1'b1; e_we = 1'b0; e_addr = 8'h30;
      f_req = 1'b1; f_addr = 8'h10;
      @(negedge clk);
      check("coll_addr", {24'b0, mem_addr}, 32'h30);
      k = 0;
      while (!e_ack && k < 20) begin @(negedge clk); k++; end
      check("coll_e_ack", {31'b0, e_ack}, 1);
      e_req = 1'b0;
      k = 0;
      while (!f_ack && k < 20) begin @(negedge clk); k++; end
      check("coll_f_ack", {31'b0, f_ack}, 1);
      check("coll_gap", k, 3);
      f_req = 1'b0;
      @(negedge clk);

      // Both requests held for ten accesses.
      for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_EN
         e.is_f = ((i % 5) == 4);
`else
         e.is_f = 1'b0;
`endif
         e.data = e.is_f ? shadow[8'h10] : shadow[8'h30];
         sb.push_back(e);
      end
      e_req = 1'b1; e_we = 1'b0; e_addr = 8'h30;
      f_req = 1'b1; f_addr = 8'h10;
      cnt = 0;
      k   = 0;
      while (cnt < 10 && k < 80) begin
         @(negedge clk);
         k++;
         if (f_ack || e_ack) cnt++;
      end
      e_req = 1'b0;
      f_req = 1'b0;
      check("starve_acks", cnt, 10);
      repeat (4) @(negedge clk);

      check("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
